// File: rtl/register_read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NUM_REQ requesters.
// Grant at edge T drives the mux select; data is registered at T+1 with a one-hot owner.
module register_read_port_arbiter_lane #(
   parameter int NUM_REQ = 4,
   parameter int PW      = 2,
   parameter int IDX     = 0
) (
   input  logic [PW-1:0]      rr_ptr,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic               grant
);
   int my_d;
   int d;

   // Lane wins when no other valid lane sits closer to rr_ptr in scan order.
   always_comb begin
      grant = req_valid[IDX];
      my_d  = (IDX + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      d     = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         d = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
         if (j != IDX && req_valid[j] && d < my_d) grant = 1'b0;
      end
   end
endmodule

module register_read_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [ADDR_WIDTH-1:0]         mux_control,
   input  logic [DATA_WIDTH-1:0]         mux_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      logic          vld;
      logic [PW-1:0] owner;
   } s1_t;

   logic [PW-1:0]         rr_ptr;
   logic [NUM_REQ-1:0]    grant;
   logic [PW-1:0]         win;
   logic [ADDR_WIDTH-1:0] addr_win;
   logic                  any;
   s1_t                   s1;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      register_read_port_arbiter_lane #(.NUM_REQ(NUM_REQ), .PW(PW), .IDX(i)) u_lane (
         .rr_ptr    (rr_ptr),
         .req_valid (req_valid),
         .grant     (grant[i])
      );
   end

   assign req_ready = reset_n ? grant : '0;
   assign any       = |grant;

   always_comb begin
      win      = '0;
      addr_win = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win      = PW'(i);
            addr_win = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mux_control <= '0;
         rr_ptr      <= '0;
         s1          <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
      end else begin
         // S0: launch the winner's index into the read mux
         if (any) begin
            mux_control <= addr_win;
            s1.owner    <= win;
            s1.vld      <= 1'b1;
            rr_ptr      <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end else begin
            s1.vld      <= 1'b0;
         end
         // S1: capture mux output for the stage-1 owner
         if (s1.vld) begin
            rsp_data  <= mux_data;
            rsp_valid <= NUM_REQ'(1) << s1.owner;
         end else begin
            rsp_valid <= '0;
         end
      end
   end
endmodule

// File: tb/tb_register_read_port_arbiter.sv
// Bench for register_read_port_arbiter: real 16-to-1 mux with data_k = 0x100+k,
// scoreboard of expected responses plus per-scenario directed checks.
module tb_register_read_port_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [15:0] req_addr;
   logic [3:0]  req_ready;
   logic [3:0]  mux_control;
   logic [31:0] mux_data;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          due;
      logic [3:0]  owner;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   register_read_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .mux_control (mux_control),
      .mux_data    (mux_data),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data)
   );

   assign mux_data = 32'h100 + {28'd0, mux_control};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard: model grants from the inputs, expect each response two edges later.
   int         mptr = 0;
   int         mj, mw;
   logic [3:0] eg, er;
   logic [31:0] ed;
   exp_t       e;
   always @(negedge clk) begin
      er = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e  = sb.pop_front();
         er = e.owner;
         ed = e.data;
      end
      checks++;
      if (rsp_valid !== er) begin
         errors++;
         $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, er);
      end
      if (er != 4'b0) begin
         checks++;
         if (rsp_data !== ed) begin
            errors++;
            $display("FAIL sb_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, ed);
         end
      end
      eg = '0;
      mw = 0;
      if (reset_n === 1'b1) begin
         for (int k = 0; k < 4; k++) begin
            mj = (mptr + k) % 4;
            if (eg == 4'b0 && req_valid[mj]) begin
               eg[mj] = 1'b1;
               mw     = mj;
            end
         end
      end
      checks++;
      if (req_ready !== eg) begin
         errors++;
         $display("FAIL sb_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
      if (reset_n !== 1'b1) begin
         sb.delete();
         mptr = 0;
      end else if (eg != 4'b0) begin
         e.due   = cyc + 2;
         e.owner = eg;
         e.data  = 32'h100 + {28'd0, req_addr[mw*4 +: 4]};
         sb.push_back(e);
         mptr = (mw + 1) % 4;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      req_addr  = 16'h3210;
      step();
      step();
      checks++;
      if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      checks++;
      if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      checks++;
      if (mux_control !== 4'd0) begin errors++; $display("FAIL reset_mux_control got=%0d exp=0", mux_control); end
      checks++;
      if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
      req_valid = 4'b0;
      reset_n   = 1'b1;
      step();
   endtask

   task automatic test_single();
      req_valid   = 4'b0001;
      req_addr    = 16'h000E;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0;
      checks++;
      if (mux_control !== 4'd14) begin errors++; $display("FAIL single_mux got=%0d exp=14", mux_control); end
      step();
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 32'h10E) begin
         errors++;
         $display("FAIL single_rsp got=%b/%h exp=0001/0000010e", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_fairness();
      logic [3:0] g;
      do_reset();
      req_valid = 4'b1111;
      req_addr  = 16'h3210;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         g = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== g) begin errors++; $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, g); end
         step();
      end
      req_valid = 4'b0;
      step();
      step();
   endtask

   task automatic test_wrap_skip();
      logic [3:0] exp_g [4];
      logic [3:0] vals  [4];
      exp_g = '{4'b0100, 4'b0010, 4'b0100, 4'b0100};
      vals  = '{4'b0100, 4'b0110, 4'b0110, 4'b0100};
      do_reset();
      req_addr = 16'h0930;
      for (int k = 0; k < 4; k++) begin
         req_valid = vals[k];
         @(negedge clk);
         checks++;
         if (req_ready !== exp_g[k]) begin
            errors++;
            $display("FAIL wrap_grant k=%0d got=%b exp=%b", k, req_ready, exp_g[k]);
         end
         step();
      end
      req_valid = 4'b0;
      step();
      step();
   endtask

   task automatic test_hog();
      req_valid = 4'b1000;
      req_addr  = 16'h5000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b1000) begin errors++; $display("FAIL hog_grant k=%0d got=%b exp=1000", k, req_ready); end
         step();
      end
      req_valid = 4'b0011;
      req_addr  = 16'h0077;
      step();
      req_valid = 4'b0;
      step();
      step();
   endtask

   task automatic test_idle_gap();
      req_valid = 4'b0001;
      req_addr  = 16'h00A6;
      step();
      req_valid = 4'b0;
      checks++;
      if (mux_control !== 4'd6) begin errors++; $display("FAIL idle_mux1 got=%0d exp=6", mux_control); end
      step();
      checks++;
      if (mux_control !== 4'd6) begin errors++; $display("FAIL idle_mux_hold got=%0d exp=6", mux_control); end
      checks++;
      if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL idle_rsp1 got=%b exp=0001", rsp_valid); end
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0;
      checks++;
      if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_rsp_gap got=%b exp=0000", rsp_valid); end
      step();
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 32'h10A) begin
         errors++;
         $display("FAIL idle_rsp2 got=%b/%h exp=0010/0000010a", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_midflight_reset();
      req_valid = 4'b0001;
      req_addr  = 16'h0005;
      step();
      req_valid = 4'b0;
      reset_n   = 1'b0;
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
         step();
      end
      req_valid = 4'b1111;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0;
      step();
      step();
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 4'b0;
      req_addr  = 16'h0;
      test_reset();
      test_single();
      test_fairness();
      test_wrap_skip();
      test_hog();
      test_idle_gap();
      test_midflight_reset();
      step();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
